mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle memory access stage between the main control FSM and the instruction/data memory. It accepts a one-cycle read or write request from control and selects the address from the PC or the ALU output (IorD). It drives the memory for a fixed number of wait cycles, captures read data into the instruction register (IR) or memory data register (MDR), and returns a one-cycle `ready` pulse so the control FSM can hold in its memory states until the access completes.

## Interface
- `DATA_WIDTH`, 32, width of address, data, IR and MDR
- `LATENCY`, 2, memory wait cycles per access; legal range 1..15
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_read`  in  1  read request from control (`mem_read`)
- `req_write`  in  1  write request from control (`mem_write`)
- `iord`  in  1  address select: 0 = `pc`, 1 = `alu_out`
- `ir_write`  in  1  read destination: 1 = IR, 0 = MDR
- `pc`  in  DATA_WIDTH  current PC
- `alu_out`  in  DATA_WIDTH  ALUOut register value (load/store address)
- `store_data`  in  DATA_WIDTH  register B value for stores
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid in last WAIT cycle
- `mem_addr`  out  DATA_WIDTH  latched access address
- `mem_wdata`  out  DATA_WIDTH  latched write data
- `mem_re`  out  1  memory read enable
- `mem_we`  out  1  memory write enable
- `busy`  out  1  access in progress (WAIT or DONE)
- `ready`  out  1  one-cycle completion pulse
- `ir`  out  DATA_WIDTH  instruction register
- `mdr`  out  DATA_WIDTH  memory data register
- `err`  out  1  sticky flag: read and write requested in the same cycle

## Operation
- States: IDLE, WAIT, DONE. Encoding is free; `busy` = (state != IDLE), `ready` = (state == DONE).
- IDLE: on a rising edge with `req_read | req_write`:
  - latch `mem_addr` = `iord ? alu_out : pc`
  - latch `mem_wdata` = `store_data`
  - latch op (read/write) and destination (`ir_write`)
  - load `cnt` = LATENCY-1; go to WAIT
- Simultaneous `req_read & req_write` in IDLE: performed as a read; `err` set to 1 and held until reset.
- WAIT:
  - `mem_re` = latched read; `mem_we` = latched write; both otherwise 0
  - `cnt` != 0: decrement `cnt`
  - `cnt` == 0: for a read, capture `mem_rdata` into IR (destination = IR) or MDR (destination = MDR); a write captures nothing. Go to DONE.
- DONE: `ready` = 1 for exactly one cycle, then go to IDLE unconditionally.
- Requests are accepted only in IDLE. Requests in WAIT or DONE are ignored and not queued.
- `mem_addr` and `mem_wdata` hold their latched values until the next accepted request. IR and MDR hold until overwritten.
- `cnt` width is 4 bits.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `cnt` = 0
  - `mem_addr`, `mem_wdata`, `ir`, `mdr` = 0
  - `mem_re`, `mem_we`, `busy`, `ready`, `err` = 0
- Reset mid-access aborts it. No IR/MDR update occurs and the enables drop in the same cycle.
- Request sampled at edge E0:
  - WAIT occupies cycles E0..E0+LATENCY; enables are high for exactly LATENCY cycles
  - `mem_rdata` is sampled at edge E0+LATENCY
  - `ready` is high in cycle E0+LATENCY..E0+LATENCY+1
  - IDLE resumes after edge E0+LATENCY+1
- Total occupancy is LATENCY+1 cycles. Back-to-back requests: the next request can be sampled no earlier than edge E0+LATENCY+2.
- IR/MDR update is visible in the same cycle `ready` rises.
- All outputs are registered or decoded from state only; there is no combinational path from request inputs to outputs.

## Test plan
- Fetch: reset, `pc`=0x00000010, `iord`=0, `ir_write`=1, `req_read` pulse, LATENCY=2, `mem_rdata`=0x00A00093 in the second WAIT cycle. Required: `mem_re` high 2 cycles, `mem_addr`=0x10, `ready` pulse in the 3rd cycle after request, `ir`=0x00A00093, `mdr`=0.
- Load: `iord`=1, `alu_out`=0x00000104, `ir_write`=0, read with `mem_rdata`=0xDEADBEEF. Required: `mdr`=0xDEADBEEF, `ir` unchanged, `mem_we` never high.
- Store: `alu_out`=0x200, `store_data`=0x12345678, `req_write` pulse. Required: `mem_we` high 2 cycles, `mem_wdata`=0x12345678, `mem_addr`=0x200, `ready` pulse, `ir` and `mdr` unchanged.
- Busy ignore: a second `req_read` with `pc`=0x20 during WAIT. Required: access count = 1, `mem_addr` remains 0x10, a single `ready` pulse.
- Conflict: `req_read`=`req_write`=1 in the same cycle. Required: read performed (`mem_re`=1, `mem_we`=0), `err`=1 persists after `ready`, cleared only by `reset`.
- Reset mid-WAIT: assert `reset` in the first WAIT cycle. Required: `mem_re`=0 and `busy`=0 immediately, `ir`=0, no `ready` pulse; a fresh request after reset completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access stage: latches a read/write request, holds the memory enables for
// LATENCY cycles, captures read data into IR or MDR and pulses ready on completion.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic                  iord,
  input  logic                  ir_write,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic                  err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  rd_q, rd_d;
  logic                  to_ir_q, to_ir_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    rd_d    = rd_q;
    to_ir_d = to_ir_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_read || req_write) begin
          addr_d  = iord ? alu_out : pc;
          wdata_d = store_data;
          // A read/write conflict is resolved as a read and flagged.
          rd_d    = req_read;
          to_ir_d = ir_write;
          cnt_d   = CntInit;
          state_d = StWait;
          if (req_read && req_write) begin
            err_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rd_q) begin
            if (to_ir_q) begin
              ir_d = mem_rdata;
            end else begin
              mdr_d = mem_rdata;
            end
          end
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      rd_q    <= 1'b0;
      to_ir_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      rd_q    <= rd_d;
      to_ir_q <= to_ir_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == StWait) && rd_q;
  assign mem_we    = (state_q == StWait) && !rd_q;
  assign busy      = (state_q != StIdle);
  assign ready     = (state_q == StDone);
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic, compared every cycle
// against a transaction-level model that tracks the edge at which each access was accepted.
module tb_mem_access_unit;

  localparam int L = 2;

  logic        clk;
  logic        reset;
  logic        req_read, req_write, iord, ir_write;
  logic [31:0] pc, alu_out, store_data, mem_rdata;
  logic [31:0] mem_addr, mem_wdata, ir, mdr;
  logic        mem_re, mem_we, busy, ready, err;

  mem_access_unit #(
    .DATA_WIDTH(32),
    .LATENCY   (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write),
    .iord      (iord),
    .ir_write  (ir_write),
    .pc        (pc),
    .alu_out   (alu_out),
    .store_data(store_data),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .busy      (busy),
    .ready     (ready),
    .ir        (ir),
    .mdr       (mdr),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model: edge counter n and edge e0 at which the current/last access was accepted.
  int          n = 0;
  int          e0 = -1000;
  logic [31:0] m_addr, m_wdata, m_ir, m_mdr;
  logic        m_rd, m_to_ir, m_err;

  int re_cnt, we_cnt, rdy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp_v, n);
    end
  endtask

  task automatic model_reset();
    e0 = -1000;
    m_addr = '0; m_wdata = '0; m_ir = '0; m_mdr = '0;
    m_rd = 1'b0; m_to_ir = 1'b0; m_err = 1'b0;
  endtask

  // Apply the effect of the coming rising edge, using the inputs currently driven.
  task automatic model_edge();
    n++;
    if (reset) begin
      model_reset();
    end else if (n - e0 >= L + 2) begin
      if (req_read || req_write) begin
        e0      = n;
        m_addr  = iord ? alu_out : pc;
        m_wdata = store_data;
        m_rd    = req_read;
        m_to_ir = ir_write;
        if (req_read && req_write) m_err = 1'b1;
      end
    end else if (n - e0 == L && m_rd) begin
      if (m_to_ir) m_ir = mem_rdata;
      else         m_mdr = mem_rdata;
    end
  endtask

  task automatic compare_all();
    int  k;
    logic in_wait, in_done;
    k       = n - e0;
    in_wait = (k >= 0) && (k < L);
    in_done = (k == L);
    check_eq("busy",      {31'b0, busy},   {31'b0, in_wait | in_done});
    check_eq("ready",     {31'b0, ready},  {31'b0, in_done});
    check_eq("mem_re",    {31'b0, mem_re}, {31'b0, in_wait & m_rd});
    check_eq("mem_we",    {31'b0, mem_we}, {31'b0, in_wait & ~m_rd});
    check_eq("mem_addr",  mem_addr,  m_addr);
    check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("ir",        ir,        m_ir);
    check_eq("mdr",       mdr,       m_mdr);
    check_eq("err",       {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic clr_stats();
    re_cnt = 0; we_cnt = 0; rdy_cnt = 0;
  endtask

  // Called with inputs set just after a falling edge; returns on the next falling edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    if (mem_re === 1'b1) re_cnt++;
    if (mem_we === 1'b1) we_cnt++;
    if (ready === 1'b1) rdy_cnt++;
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int cnt);
    req_read = 1'b0; req_write = 1'b0;
    for (int i = 0; i < cnt; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    req_read = 1'b0; req_write = 1'b0; iord = 1'b0; ir_write = 1'b0;
    pc = '0; alu_out = '0; store_data = '0; mem_rdata = '0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Fetch into IR.
    clr_stats();
    pc = 32'h10; iord = 1'b0; ir_write = 1'b1; mem_rdata = 32'h00A00093;
    req_read = 1'b1;
    tick();
    check_eq("fetch_addr", mem_addr, 32'h10);
    req_read = 1'b0;
    tick();
    tick();
    check_eq("fetch_ready_3rd", {31'b0, ready}, 32'd1);
    tick();
    check_eq("fetch_re_cycles", 32'(re_cnt), 32'd2);
    check_eq("fetch_ir", ir, 32'h00A00093);
    check_eq("fetch_mdr", mdr, 32'h0);
    check_eq("fetch_ready_cnt", 32'(rdy_cnt), 32'd1);

    // Load into MDR.
    clr_stats();
    iord = 1'b1; alu_out = 32'h104; ir_write = 1'b0; mem_rdata = 32'hDEADBEEF;
    req_read = 1'b1;
    tick();
    idle_ticks(3);
    check_eq("load_mdr", mdr, 32'hDEADBEEF);
    check_eq("load_ir_kept", ir, 32'h00A00093);
    check_eq("load_we_cycles", 32'(we_cnt), 32'd0);
    check_eq("load_addr", mem_addr, 32'h104);

    // Store.
    clr_stats();
    alu_out = 32'h200; store_data = 32'h12345678; mem_rdata = 32'h55555555;
    req_write = 1'b1;
    tick();
    idle_ticks(3);
    check_eq("store_we_cycles", 32'(we_cnt), 32'd2);
    check_eq("store_re_cycles", 32'(re_cnt), 32'd0);
    check_eq("store_wdata", mem_wdata, 32'h12345678);
    check_eq("store_addr", mem_addr, 32'h200);
    check_eq("store_ready_cnt", 32'(rdy_cnt), 32'd1);
    check_eq("store_ir_kept", ir, 32'h00A00093);
    check_eq("store_mdr_kept", mdr, 32'hDEADBEEF);

    // Request during WAIT is dropped.
    clr_stats();
    iord = 1'b0; pc = 32'h10; ir_write = 1'b1; mem_rdata = 32'h0BADF00D;
    req_read = 1'b1;
    tick();
    pc = 32'h20;
    tick();
    idle_ticks(4);
    check_eq("ignore_re_cycles", 32'(re_cnt), 32'd2);
    check_eq("ignore_addr", mem_addr, 32'h10);
    check_eq("ignore_ready_cnt", 32'(rdy_cnt), 32'd1);
    check_eq("ignore_ir", ir, 32'h0BADF00D);

    // Read/write conflict.
    clr_stats();
    ir_write = 1'b0; pc = 32'h30; mem_rdata = 32'h13579BDF;
    req_read = 1'b1; req_write = 1'b1;
    tick();
    idle_ticks(5);
    check_eq("conflict_re_cycles", 32'(re_cnt), 32'd2);
    check_eq("conflict_we_cycles", 32'(we_cnt), 32'd0);
    check_eq("conflict_err", {31'b0, err}, 32'd1);
    check_eq("conflict_mdr", mdr, 32'h13579BDF);

    // Reset in the first WAIT cycle.
    ir_write = 1'b1; pc = 32'h40; mem_rdata = 32'hFFFF0000;
    req_read = 1'b1;
    tick();
    req_read = 1'b0;
    clr_stats();
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_ir", ir, 32'h0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    idle_ticks(2);
    check_eq("rst_no_ready", 32'(rdy_cnt), 32'd0);
    mem_rdata = 32'hCAFEF00D; pc = 32'h44;
    req_read = 1'b1;
    tick();
    idle_ticks(3);
    check_eq("rst_fresh_ir", ir, 32'hCAFEF00D);
    check_eq("rst_fresh_ready", 32'(rdy_cnt), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req_read   = ($urandom_range(0, 2) == 0);
      req_write  = ($urandom_range(0, 3) == 0) && ($urandom_range(0, 3) != 0 || !req_read);
      iord       = 1'($urandom_range(0, 1));
      ir_write   = 1'($urandom_range(0, 1));
      pc         = $urandom;
      alu_out    = $urandom;
      store_data = $urandom;
      mem_rdata  = $urandom;
      if (i == 300) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
